// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter.
//   arb_state_t : arbiter FSM states
//   arb_grant_t : which cache holds / receives the memory port
//   ARB_ADDR_WIDTH / ARB_LINE_WIDTH : default byte-address and line widths
package cache_arb_types;

   localparam int ARB_ADDR_WIDTH = 32;
   localparam int ARB_LINE_WIDTH = 256;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ICACHE = 2'd1,
      ARB_DCACHE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } arb_grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Line-port bundle between icache, dcache, the arbiter and physical memory.
//   i_pmem_*  : icache line-read request / response
//   d_pmem_*  : dcache line-read / writeback request / response
//   pmem_*    : single shared memory line port
// Modports:
//   slave  : the arbiter's view (takes cache requests, drives memory strobes)
//   master : the environment's view (caches and memory)
interface cache_arbiter_if #(
   parameter int ADDR_WIDTH = cache_arb_types::ARB_ADDR_WIDTH,
   parameter int LINE_WIDTH = cache_arb_types::ARB_LINE_WIDTH
);
   logic                  i_pmem_read;
   logic [ADDR_WIDTH-1:0] i_pmem_address;
   logic                  i_pmem_resp;
   logic [LINE_WIDTH-1:0] i_pmem_rdata;

   logic                  d_pmem_read;
   logic                  d_pmem_write;
   logic [ADDR_WIDTH-1:0] d_pmem_address;
   logic [LINE_WIDTH-1:0] d_pmem_wdata;
   logic                  d_pmem_resp;
   logic [LINE_WIDTH-1:0] d_pmem_rdata;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic                  pmem_resp;
   logic [LINE_WIDTH-1:0] pmem_rdata;

   modport slave (
      input  i_pmem_read, i_pmem_address,
      output i_pmem_resp, i_pmem_rdata,
      input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      output d_pmem_resp, d_pmem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata
   );

   modport master (
      output i_pmem_read, i_pmem_address,
      input  i_pmem_resp, i_pmem_rdata,
      output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
      input  d_pmem_resp, d_pmem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata
   );

endinterface

// File: rtl/cache_arbiter_grant_sel.sv
// Grant selection for the cache arbiter (purely combinational grant).
// Build option ARBITER_RR_EN:
//   defined   : round-robin on contention; a last-grant flag (reset to dcache)
//               is kept here and updated on every accepted grant
//   undefined : fixed priority, dcache wins contention; no flag exists
// Ports:
//   clk, rst     : clock and synchronous active-high reset (flag only)
//   req_i, req_d : pending icache / dcache requests
//   take         : the arbiter accepts the grant this cycle
//   grant        : selected cache
module arb_grant_sel
   import cache_arb_types::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_i,
   input  logic       req_d,
   input  logic       take,
   output arb_grant_t grant
);

`ifdef ARBITER_RR_EN
   arb_grant_t last_q, last_d;

   always_comb begin
      grant  = GRANT_I;
      last_d = last_q;
      if (req_i && req_d) begin
         if (last_q == GRANT_D) grant = GRANT_I;
         else                   grant = GRANT_D;
      end else if (req_d) begin
         grant = GRANT_D;
      end
      if (take) last_d = grant;
   end

   // Reset to dcache so the first contended grant goes to the icache.
   always_ff @(posedge clk) begin
      if (rst) last_q <= GRANT_D;
      else     last_q <= last_d;
   end
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, rst, take, req_i};

   always_comb begin
      grant = GRANT_I;
      if (req_d) grant = GRANT_D;
   end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the icache and dcache.
// One full-line transaction is outstanding at a time; the winning request
// is latched on grant and memory is driven only from the latched copy.
// Responses are routed combinationally from pmem_resp to the granted cache.
// Grant policy comes from arb_grant_sel (build option ARBITER_RR_EN).
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : cache_arbiter_if.slave (cache request/response and memory port)
//
// state      | meaning
// ARB_IDLE   | no strobes; grant a pending request and latch it
// ARB_ICACHE | icache line read on memory, waiting for pmem_resp
// ARB_DCACHE | dcache read or writeback on memory, waiting for pmem_resp
module cache_arbiter
   import cache_arb_types::*;
#(
   parameter int ADDR_WIDTH = ARB_ADDR_WIDTH,
   parameter int LINE_WIDTH = ARB_LINE_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   cache_arbiter_if.slave bus
);

   arb_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
   logic                  write_q, write_d;

   logic       req_i, req_d, grant_take;
   arb_grant_t grant;

   assign req_i      = bus.i_pmem_read;
   assign req_d      = bus.d_pmem_read | bus.d_pmem_write;
   assign grant_take = (state_q == ARB_IDLE) & (req_i | req_d);

   arb_grant_sel u_grant_sel (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_i),
      .req_d (req_d),
      .take  (grant_take),
      .grant (grant)
   );

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      write_d         = write_q;
      bus.pmem_read   = 1'b0;
      bus.pmem_write  = 1'b0;
      bus.i_pmem_resp = 1'b0;
      bus.d_pmem_resp = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (grant_take) begin
               if (grant == GRANT_D) begin
                  state_d = ARB_DCACHE;
                  addr_d  = bus.d_pmem_address;
                  wdata_d = bus.d_pmem_wdata;
                  // Writeback wins over a simultaneous read; the dcache
                  // re-issues the read after this response.
                  write_d = bus.d_pmem_write;
               end else begin
                  state_d = ARB_ICACHE;
                  addr_d  = bus.i_pmem_address;
                  write_d = 1'b0;
               end
            end
         end
         ARB_ICACHE: begin
            bus.pmem_read   = 1'b1;
            bus.i_pmem_resp = bus.pmem_resp;
            if (bus.pmem_resp) state_d = ARB_IDLE;
         end
         ARB_DCACHE: begin
            bus.pmem_read   = ~write_q;
            bus.pmem_write  = write_q;
            bus.d_pmem_resp = bus.pmem_resp;
            if (bus.pmem_resp) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign bus.pmem_address = addr_q;
   assign bus.pmem_wdata   = wdata_q;
   assign bus.i_pmem_rdata = bus.pmem_rdata;
   assign bus.d_pmem_rdata = bus.pmem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
      end
   end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;
   import cache_arb_types::*;

   localparam int AW       = ARB_ADDR_WIDTH;
   localparam int LW       = ARB_LINE_WIDTH;
   localparam int TAG_I    = 0;
   localparam int TAG_D    = 1;
   localparam int TAG_NONE = 2;

   typedef struct {
      int          tag;
      bit          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic [LW-1:0] rdata;
      int          start;
      bit          follow;
      int          delay;
      bit          abort;
   } mem_exp_t;

   typedef struct {
      int          tag;
      logic [LW-1:0] rdata;
   } resp_exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   model_last;
   bit   stray_req = 1'b0;
   int   last_resp_cyc = -100;

   mem_exp_t  exp_mem_q[$];
   resp_exp_t exp_resp_q[$];

   cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_addr(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic fail_msg(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference grant rule on contention.
   function automatic int model_winner();
`ifdef ARBITER_RR_EN
      return (model_last == TAG_D) ? TAG_I : TAG_D;
`else
      return TAG_D;
`endif
   endfunction

   function automatic mem_exp_t mk(input int tag, input bit wr, input logic [AW-1:0] a,
                                   input logic [LW-1:0] w, input int start, input bit follow);
      mem_exp_t e;
      e.tag    = tag;
      e.wr     = wr;
      e.addr   = a;
      e.wdata  = w;
      e.rdata  = rand_line();
      e.start  = start;
      e.follow = follow;
      e.delay  = int'($urandom_range(1, 5));
      e.abort  = 1'b0;
      return e;
   endfunction

   // Memory model plus scoreboard: checks each memory transaction against
   // the expected order and each cache response against what memory returned.
   initial begin : mem_sb
      mem_exp_t  cur;
      resp_exp_t r;
      bit        busy;
      int        lat;
      busy = 1'b0;
      lat  = 0;
      cur  = mk(TAG_NONE, 1'b0, '0, '0, -1, 1'b0);
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.pmem_resp) begin
            if (exp_resp_q.size() == 0) begin
               fail_msg("resp_unexpected", "pmem_resp with nothing expected");
            end else begin
               r = exp_resp_q.pop_front();
               chk_bit("i_pmem_resp", bus.i_pmem_resp, r.tag == TAG_I);
               chk_bit("d_pmem_resp", bus.d_pmem_resp, r.tag == TAG_D);
               if (r.tag == TAG_I) chk_line("i_pmem_rdata", bus.i_pmem_rdata, r.rdata);
               if (r.tag == TAG_D) chk_line("d_pmem_rdata", bus.d_pmem_rdata, r.rdata);
               if (r.tag != TAG_NONE) last_resp_cyc = cyc;
            end
         end else begin
            chk_bit("i_resp_idle", bus.i_pmem_resp, 1'b0);
            chk_bit("d_resp_idle", bus.d_pmem_resp, 1'b0);
         end

         if (busy) begin
            if (!(bus.pmem_read || bus.pmem_write)) begin
               if (!cur.abort) fail_msg("strobe_dropped", "strobe fell before pmem_resp");
               busy = 1'b0;
            end else begin
               chk_bit("hold_read", bus.pmem_read, !cur.wr);
               chk_bit("hold_write", bus.pmem_write, cur.wr);
               chk_addr("hold_addr", bus.pmem_address, cur.addr);
               if (cur.wr) chk_line("hold_wdata", bus.pmem_wdata, cur.wdata);
            end
         end else if (bus.pmem_read || bus.pmem_write) begin
            if (exp_mem_q.size() == 0) begin
               fail_msg("txn_unexpected", "memory strobe with no request pending");
               cur.abort = 1'b1;
               busy = 1'b1;
            end else begin
               cur = exp_mem_q.pop_front();
               chk_bit("txn_read", bus.pmem_read, !cur.wr);
               chk_bit("txn_write", bus.pmem_write, cur.wr);
               chk_addr("txn_addr", bus.pmem_address, cur.addr);
               if (cur.wr) chk_line("txn_wdata", bus.pmem_wdata, cur.wdata);
               if (cur.start >= 0) chk_int("txn_start_cycle", cyc, cur.start);
               if (cur.follow) chk_int("txn_after_idle", cyc, last_resp_cyc + 2);
               busy = 1'b1;
               lat  = cur.delay - 1;
            end
         end

         @(posedge clk);
         #1;
         if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            busy = 1'b0;
         end else if (busy && !cur.abort) begin
            if (lat == 0) begin
               bus.pmem_resp  = 1'b1;
               bus.pmem_rdata = cur.rdata;
               r.tag   = cur.tag;
               r.rdata = cur.rdata;
               exp_resp_q.push_back(r);
            end else begin
               lat--;
            end
         end else if (!busy && stray_req) begin
            stray_req      = 1'b0;
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rand_line();
            r.tag   = TAG_NONE;
            r.rdata = bus.pmem_rdata;
            exp_resp_q.push_back(r);
         end
      end
   end

   task automatic wait_resp(input bit is_d, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
         @(negedge clk);
         ok = is_d ? bus.d_pmem_resp : bus.i_pmem_resp;
      end
      @(posedge clk);
      #1;
      if (!ok) fail_msg(is_d ? "d_resp_timeout" : "i_resp_timeout", "no response within 300 cycles");
   endtask

   task automatic i_access(input logic [AW-1:0] a, input bit scramble, input logic [AW-1:0] alt);
      bit ok;
      bus.i_pmem_read    = 1'b1;
      bus.i_pmem_address = a;
      @(posedge clk);
      #1;
      if (scramble) bus.i_pmem_address = alt;
      wait_resp(1'b0, ok);
      bus.i_pmem_read = 1'b0;
   endtask

   task automatic d_access(input bit wr, input bit rd, input logic [AW-1:0] a,
                           input logic [LW-1:0] w, input bit scramble);
      bit ok;
      bus.d_pmem_write   = wr;
      bus.d_pmem_read    = rd;
      bus.d_pmem_address = a;
      bus.d_pmem_wdata   = w;
      @(posedge clk);
      #1;
      if (scramble) begin
         bus.d_pmem_address = $urandom;
         bus.d_pmem_wdata   = rand_line();
      end
      wait_resp(1'b1, ok);
      bus.d_pmem_write = 1'b0;
      bus.d_pmem_read  = 1'b0;
   endtask

   // One round of requests issued together while the arbiter is idle.
   task automatic round(input bit ri, input bit dwr, input bit drd);
      logic [AW-1:0] ai, ad;
      logic [LW-1:0] wd;
      bit rd;
      int w;
      rd = dwr | drd;
      ai = $urandom;
      ad = ai ^ 32'h8000_0040;
      wd = rand_line();
      if (ri && rd) w = model_winner();
      else          w = rd ? TAG_D : TAG_I;
      if (w == TAG_I) begin
         exp_mem_q.push_back(mk(TAG_I, 1'b0, ai, '0, cyc + 1, 1'b0));
         if (rd) exp_mem_q.push_back(mk(TAG_D, dwr, ad, wd, -1, 1'b1));
      end else begin
         exp_mem_q.push_back(mk(TAG_D, dwr, ad, wd, cyc + 1, 1'b0));
         if (ri) exp_mem_q.push_back(mk(TAG_I, 1'b0, ai, '0, -1, 1'b1));
      end
      if (ri && rd) model_last = (w == TAG_I) ? TAG_D : TAG_I;
      else          model_last = w;
      fork
         begin
            if (ri) i_access(ai, w == TAG_I, $urandom);
         end
         begin
            if (rd) d_access(dwr, drd, ad, wd, w == TAG_D);
         end
      join
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      mem_exp_t e;
      int sel, dop;
      rst = 1'b1;
      bus.i_pmem_read    = 1'b0;
      bus.i_pmem_address = '0;
      bus.d_pmem_read    = 1'b0;
      bus.d_pmem_write   = 1'b0;
      bus.d_pmem_address = '0;
      bus.d_pmem_wdata   = '0;
      model_last = TAG_D;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_bit("rst_pmem_read", bus.pmem_read, 1'b0);
      chk_bit("rst_pmem_write", bus.pmem_write, 1'b0);
      chk_addr("rst_pmem_address", bus.pmem_address, '0);
      chk_line("rst_pmem_wdata", bus.pmem_wdata, '0);
      chk_bit("rst_i_resp", bus.i_pmem_resp, 1'b0);
      chk_bit("rst_d_resp", bus.d_pmem_resp, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Contention twice straight after reset.
      round(1'b1, 1'b0, 1'b1);
      round(1'b1, 1'b0, 1'b1);

      // Icache read of 0x60, address moves to 0x200 mid-flight, 3-cycle memory.
      e = mk(TAG_I, 1'b0, 32'h0000_0060, '0, cyc + 1, 1'b0);
      e.delay = 3;
      e.rdata = {32{8'hA5}};
      exp_mem_q.push_back(e);
      model_last = TAG_I;
      i_access(32'h0000_0060, 1'b1, 32'h0000_0200);

      // Dcache writeback, then its read issued in the idle cycle after.
      exp_mem_q.push_back(mk(TAG_D, 1'b1, 32'h1000_0020, {8{32'hDEAD_BEEF}}, cyc + 1, 1'b0));
      exp_mem_q.push_back(mk(TAG_D, 1'b0, 32'h1000_0040, '0, -1, 1'b1));
      model_last = TAG_D;
      d_access(1'b1, 1'b0, 32'h1000_0020, {8{32'hDEAD_BEEF}}, 1'b1);
      d_access(1'b0, 1'b1, 32'h1000_0040, '0, 1'b1);

      // Read and write together: latched as a write.
      round(1'b0, 1'b1, 1'b1);

      // Reset two cycles into a dcache read, then a stray pmem_resp.
      e = mk(TAG_D, 1'b0, 32'h0000_abc0, '0, cyc + 1, 1'b0);
      e.abort = 1'b1;
      exp_mem_q.push_back(e);
      bus.d_pmem_read    = 1'b1;
      bus.d_pmem_address = 32'h0000_abc0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.d_pmem_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_last = TAG_D;
      @(negedge clk);
      chk_bit("abort_pmem_read", bus.pmem_read, 1'b0);
      chk_bit("abort_pmem_write", bus.pmem_write, 1'b0);
      chk_addr("abort_pmem_address", bus.pmem_address, '0);
      chk_bit("abort_i_resp", bus.i_pmem_resp, 1'b0);
      chk_bit("abort_d_resp", bus.d_pmem_resp, 1'b0);
      stray_req = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk_bit("stray_pmem_read", bus.pmem_read, 1'b0);
      chk_bit("stray_pmem_write", bus.pmem_write, 1'b0);
      @(posedge clk);
      #1;

      // Contention again after the mid-run reset.
      round(1'b1, 1'b0, 1'b1);

      // Randomized rounds.
      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 2));
         dop = int'($urandom_range(0, 2));
         round(sel != 1, (sel != 0) && (dop != 0), (sel != 0) && (dop != 1));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk_int("exp_mem_left", exp_mem_q.size(), 0);
      chk_int("exp_resp_left", exp_resp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single physical-memory line port between the instruction cache and the data cache. Sits between the two cache instances' pmem-side ports and the main-memory or L2 interface. It serializes line transactions, latches the winning request, and routes the memory response back to the granted cache. One transaction is outstanding at a time, and each transaction is one full line.

## Interface
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_pmem_read  in  1  icache line read request.
- i_pmem_address  in  ADDR_WIDTH  icache line address.
- i_pmem_resp  out  1  icache transaction done.
- i_pmem_rdata  out  LINE_WIDTH  icache read line.
- d_pmem_read  in  1  dcache line read request.
- d_pmem_write  in  1  dcache line writeback request.
- d_pmem_address  in  ADDR_WIDTH  dcache line address.
- d_pmem_wdata  in  LINE_WIDTH  dcache writeback line.
- d_pmem_resp  out  1  dcache transaction done.
- d_pmem_rdata  out  LINE_WIDTH  dcache read line.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_WIDTH  memory line address.
- pmem_wdata  out  LINE_WIDTH  memory write line.
- pmem_resp  in  1  memory done; single-cycle pulse.
- pmem_rdata  in  LINE_WIDTH  memory read line, valid with pmem_resp.

## Operation
- FSM states: ARB_IDLE, ARB_ICACHE, ARB_DCACHE.
- ARB_IDLE:
  - No memory strobes are driven.
  - A pending request is selected by the grant rule (see Configuration).
  - On the selection edge, the FSM moves to the granted state and latches address, opcode (read/write) and wdata into internal registers.
- ARB_ICACHE / ARB_DCACHE:
  - Memory strobes and address are driven from the latched registers, never from live requester inputs.
  - The state is held until pmem_resp.
  - On pmem_resp, the granted requester's *_resp is asserted in the same cycle, combinationally from pmem_resp. The FSM returns to ARB_IDLE on that edge.
- Read data: i_pmem_rdata and d_pmem_rdata are both wired to pmem_rdata. Data is meaningful only while the matching *_resp is high.
- Dcache read and write asserted together: write wins, and the request is latched as a write. The dcache re-requests the read after the writeback response.
- Requesters must deassert their request in the cycle after their *_resp. Because the arbiter returns to ARB_IDLE, a request still asserted in ARB_IDLE is treated as a new request.
- pmem_resp while in ARB_IDLE is ignored: no *_resp is asserted and the state does not change.
- The non-granted requester's *_resp stays 0 throughout.

## Timing
- Reset values:
  - State ARB_IDLE.
  - pmem_read, pmem_write, i_pmem_resp, d_pmem_resp = 0.
  - pmem_address = 0 and pmem_wdata = 0 (latch registers cleared).
  - Last-grant flag = dcache.
- rst mid-transaction: the FSM returns to ARB_IDLE on the next edge and strobes drop, with no response to either requester. Memory-side abort is the system's responsibility.
- Latency from request to memory strobe is 1 cycle: request seen at edge N, pmem_read/pmem_write high from cycle N+1.
- Back-to-back transactions have at least one ARB_IDLE cycle between the response and the next memory strobe.
- Arbiter-added latency per transaction is 1 cycle. The response path has zero added latency.

## Configuration
- ARBITER_RR_EN defined: round-robin grant.
  - When both caches request in ARB_IDLE, the cache not granted last wins.
  - The last-grant flag updates on every grant.
  - After reset, the first contended grant goes to the icache.
- ARBITER_RR_EN undefined: fixed priority, where the dcache always wins contention. The last-grant flag is not implemented.
- An uncontended request is granted immediately in both builds.

## Structure
- Shared package cache_arb_types contains:
  - arb_state_t enum (ARB_IDLE, ARB_ICACHE, ARB_DCACHE).
  - arb_grant_t enum (GRANT_I, GRANT_D).
  - Default line and address width localparams.
- One sub-module, arb_grant_sel, computes the grant combinationally from the two request lines and the last-grant flag. The ARBITER_RR_EN conditional lives in this sub-module only.
- The FSM, latch registers and output muxing live in cache_arbiter.

## Test plan
- **Icache-only read:** i_pmem_read=1, i_pmem_address=0x0000_0060, memory responds 3 cycles after strobe with rdata=all 0xA5 bytes. Required: pmem_read from cycle 1 with pmem_address=0x60; i_pmem_resp=1 with i_pmem_rdata=0xA5.. in the response cycle; d_pmem_resp stays 0.
- **Dcache writeback then read:**
  - Writeback: d_pmem_write at address 0x1000_0020 with wdata=0xDEAD_BEEF repeated. Required: pmem_write=1 and pmem_wdata latched, held until pmem_resp, then d_pmem_resp=1.
  - Read: the following d_pmem_read of 0x1000_0040. Required: a second transaction starting after one ARB_IDLE cycle.
- **Simultaneous requests, ARBITER_RR_EN defined:** both caches request, twice in succession. Required grant order after reset is icache, dcache, icache.
- **Same stimulus, ARBITER_RR_EN undefined:** required: the dcache is granted first on every contention.
- **Input stability:** i_pmem_address changes to 0x200 mid-transaction. Required: pmem_address remains at the latched value 0x60 until the response.
- **rst asserted 2 cycles into a dcache read:** required next cycle: pmem_read=0, ARB_IDLE, no *_resp. A stray pmem_resp arriving afterwards is ignored.
